dsp_reset_responder: RTL and testbench

DSP_RESET_RESPONDER -- requirements
Module: dsp_reset_responder

---
 rtl/dsp_pkg.sv | 25 ++
 rtl/dsp_cycle_counter.sv | 17 +
 rtl/dsp_reset_responder.sv | 100 ++++++++++
 tb/tb_dsp_reset_responder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared types and constants for the DSP reset/ready responder.
package dsp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RST_HIGH,
        ST_RST_WAIT,
        ST_READY
    } dsp_state_e;

    // Port offsets relative to BASE_ADDRESS
    localparam logic [15:0] RESET_OFS  = 16'h0006;
    localparam logic [15:0] READ_OFS   = 16'h000A;
    localparam logic [15:0] STATUS_OFS = 16'h000E;

    localparam logic [7:0] READY_BYTE  = 8'hAA;
    localparam logic [6:0] STATUS_MASK = 7'h7F;

    typedef struct packed {
        logic wr_reset;
        logic rd_read;
        logic rd_status;
    } dsp_dec_t;

endpackage

// File: rtl/dsp_cycle_counter.sv
// 16-bit saturating up-counter with synchronous clear and count enable.
module dsp_cycle_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    output logic [15:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clr)
            count <= 16'h0000;
        else if (en && count != 16'hFFFF)
            count <= count + 16'd1;
    end

endmodule

// File: rtl/dsp_reset_responder.sv
// DSP reset/ready handshake responder: reset port, read-data port, status port.
// Optional DSP_STRICT_HOLD_EN: release before HOLD_CYCLES aborts back to IDLE.
module dsp_reset_responder
    import dsp_pkg::*;
#(
    parameter logic [15:0] BASE_ADDRESS = 16'h0220,
    parameter logic [15:0] HOLD_CYCLES  = 16'd150,
    parameter logic [15:0] READY_CYCLES = 16'd5000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_en,
    input  logic [15:0] address,
    input  logic [15:0] data_in,
    input  logic        data_dir,
    output logic [15:0] data_out,
    output logic        data_oe,
    output logic        dsp_ready
);

`ifdef DSP_STRICT_HOLD_EN
    localparam bit STRICT_HOLD = 1'b1;
`else
    localparam bit STRICT_HOLD = 1'b0;
`endif

    dsp_state_e  state, state_nxt;
    dsp_dec_t    dec;
    logic [15:0] count;
    logic        cnt_clr, cnt_en, hold_ok;
    logic        unused_data;

    assign unused_data = ^data_in[15:1];

    assign dec.wr_reset  = bus_en &  data_dir & (address == BASE_ADDRESS + RESET_OFS);
    assign dec.rd_read   = bus_en & ~data_dir & (address == BASE_ADDRESS + READ_OFS);
    assign dec.rd_status = bus_en & ~data_dir & (address == BASE_ADDRESS + STATUS_OFS);

    assign hold_ok = !STRICT_HOLD || (count >= HOLD_CYCLES);

    dsp_cycle_counter u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        case (state)
            ST_RST_HIGH: begin
                cnt_en = 1'b1;
                if (dec.wr_reset && !data_in[0]) begin
                    cnt_clr   = 1'b1;
                    state_nxt = hold_ok ? ST_RST_WAIT : ST_IDLE;
                end
            end
            ST_RST_WAIT: begin
                cnt_en = 1'b1;
                if (count == READY_CYCLES - 16'd1)
                    state_nxt = ST_READY;
            end
            ST_READY: begin
                if (dec.rd_read)
                    state_nxt = ST_IDLE;
            end
            default: ;
        endcase
        // Assert write wins over everything, including the read side effect
        if (dec.wr_reset && data_in[0]) begin
            cnt_clr   = 1'b1;
            state_nxt = ST_RST_HIGH;
        end
    end

    assign dsp_ready = (state == ST_READY);

    always_comb begin
        data_oe  = 1'b0;
        data_out = 16'h0000;
        if (dec.rd_status) begin
            data_oe  = 1'b1;
            data_out = {8'h00, dsp_ready, STATUS_MASK};
        end else if (dec.rd_read) begin
            data_oe  = 1'b1;
            data_out = dsp_ready ? {8'h00, READY_BYTE} : 16'h0000;
        end
    end

endmodule

// File: tb/tb_dsp_reset_responder.sv
// Scoreboard bench for dsp_reset_responder: driver queues expected read data,
// a negedge monitor pops and compares whenever data_oe is asserted.
module tb_dsp_reset_responder;

    localparam logic [15:0] BASE = 16'h0220;
    localparam logic [15:0] A_RST  = BASE + 16'h6;
    localparam logic [15:0] A_RD   = BASE + 16'hA;
    localparam logic [15:0] A_STAT = BASE + 16'hE;
    localparam logic [15:0] A_BAD  = BASE + 16'h7;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        bus_en = 1'b0;
    logic [15:0] address = 16'h0000;
    logic [15:0] data_in = 16'h0000;
    logic        data_dir = 1'b0;
    logic [15:0] data_out;
    logic        data_oe;
    logic        dsp_ready;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_q[$];

    dsp_reset_responder dut (
        .clk       (clk),
        .reset     (reset),
        .bus_en    (bus_en),
        .address   (address),
        .data_in   (data_in),
        .data_dir  (data_dir),
        .data_out  (data_out),
        .data_oe   (data_oe),
        .dsp_ready (dsp_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every presented read is matched against the next queued value
    always @(negedge clk) begin
        if (data_oe === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_read: got data_out %h with no expected entry at %0t", data_out, $time);
            end else begin
                chk("read_data", {16'h0, data_out}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_idle();
        bus_en   = 1'b0;
        data_dir = 1'b0;
        address  = 16'h0000;
        data_in  = 16'h0000;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        bus_en = 1'b1; data_dir = 1'b1; address = a; data_in = d;
        tick(1);
        bus_idle();
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] exp);
        bus_en = 1'b1; data_dir = 1'b0; address = a;
        exp_q.push_back(exp);
        tick(1);
        bus_idle();
    endtask

    // Access that must not be decoded: no drive, zero data
    task automatic quiet(input string name, input logic en, input logic dir,
                         input logic [15:0] a, input logic [15:0] d);
        bus_en = en; data_dir = dir; address = a; data_in = d;
        @(negedge clk);
        chk({name, "_oe"}, {31'h0, data_oe}, 32'h0);
        chk({name, "_data"}, {16'h0, data_out}, 32'h0);
        @(posedge clk);
        #1;
        bus_idle();
    endtask

    task automatic full_reset_seq();
        wr(A_RST, 16'h0001);
        tick(150);
        wr(A_RST, 16'h0000);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, queue depth %0d", exp_q.size());
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw_ready;
        tick(3);
        reset = 1'b0;
        tick(1);
        chk("reset_ready", {31'h0, dsp_ready}, 32'h0);
        chk("reset_oe", {31'h0, data_oe}, 32'h0);
        chk("reset_data", {16'h0, data_out}, 32'h0);
        rd(A_STAT, 16'h007F);
        rd(A_RD, 16'h0000);

        // Full handshake with cycle-exact ready boundary
        full_reset_seq();
        for (int i = 0; i < 5000; i++) rd(A_STAT, 16'h007F);
        rd(A_STAT, 16'h00FF);
        chk("ready_flag", {31'h0, dsp_ready}, 32'h1);

        // Undecoded accesses in READY: no drive, no state change
        quiet("noen_stat", 1'b0, 1'b0, A_STAT, 16'h0000);
        quiet("noen_read", 1'b0, 1'b0, A_RD, 16'h0000);
        quiet("noen_wr1", 1'b0, 1'b1, A_RST, 16'h0001);
        quiet("bad_rd", 1'b1, 1'b0, A_BAD, 16'h0000);
        quiet("bad_wr1", 1'b1, 1'b1, A_BAD, 16'h0001);
        chk("decoy_keeps_ready", {31'h0, dsp_ready}, 32'h1);
        wr(A_RST, 16'h0000);
        chk("wr0_in_ready_ignored", {31'h0, dsp_ready}, 32'h1);

        rd(A_RD, 16'h00AA);
        chk("ready_falls_after_read", {31'h0, dsp_ready}, 32'h0);
        rd(A_STAT, 16'h007F);
        rd(A_RD, 16'h0000);

        // Re-assert from READY, then a complete new sequence
        full_reset_seq();
        tick(5000);
        chk("second_ready", {31'h0, dsp_ready}, 32'h1);
        wr(A_RST, 16'h0001);
        chk("reassert_drops_ready", {31'h0, dsp_ready}, 32'h0);
        rd(A_STAT, 16'h007F);
        tick(149);
        wr(A_RST, 16'h0000);
        tick(4999);
        rd(A_STAT, 16'h007F);
        rd(A_STAT, 16'h00FF);
        rd(A_RD, 16'h00AA);

        // Synchronous reset mid RST_WAIT
        full_reset_seq();
        tick(2000);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("midwait_reset_ready", {31'h0, dsp_ready}, 32'h0);
        rd(A_STAT, 16'h007F);
        saw_ready = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            tick(1);
            if (dsp_ready) saw_ready = 1'b1;
        end
        chk("midwait_reset_no_ready", {31'h0, saw_ready}, 32'h0);
        rd(A_STAT, 16'h007F);

        // Early release: aborted under strict hold, accepted otherwise
        wr(A_RST, 16'h0001);
        tick(10);
        wr(A_RST, 16'h0000);
        tick(5100);
`ifdef DSP_STRICT_HOLD_EN
        rd(A_STAT, 16'h007F);
        chk("early_release_aborted", {31'h0, dsp_ready}, 32'h0);
`else
        rd(A_STAT, 16'h00FF);
        chk("early_release_accepted", {31'h0, dsp_ready}, 32'h1);
        rd(A_RD, 16'h00AA);
`endif

        tick(3);
        chk("scoreboard_drained", exp_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
